// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: one full-subtractor cell is stepped LSB-first
// across WIDTH bits, with valid/ready handshakes on the operand and result sides.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             brw;
  logic             brw_next;
  logic             d_bit;
  logic             last_bit;
  logic [CW-1:0]    bit_cnt;

  // The shared full-subtractor cell, fed from the LSBs of the operand shifters.
  assign d_bit    = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
  assign res_next = {d_bit, res_sh[WIDTH-1:1]};
  assign last_bit = (bit_cnt == LAST_BIT);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state <= RUN;
        RUN: begin
          if (abort)         state <= IDLE;
          else if (last_bit) state <= DONE;
        end
        DONE: if (abort || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // An abort freezes the datapath so diff/bout retain the last completed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      brw     <= 1'b0;
      bit_cnt <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            brw     <= bin;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            brw    <= brw_next;
            if (last_bit) begin
              diff    <= res_next;
              bout    <= brw_next;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that time-shares one 1-bit full-subtractor cell across a WIDTH-bit operation. It accepts an operand pair and a borrow-in over a valid/ready handshake, then steps the cell LSB-first for WIDTH cycles while carrying the borrow in a flip-flop. It presents the WIDTH-bit difference and final borrow-out on a held output handshake. It sits between an operand source (generator or bus front-end) and a result consumer, and is the sequencing layer above the existing full-subtractor datapath.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair and borrow-in are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  minuend; sampled on accept.
- b  input  WIDTH  subtrahend; sampled on accept.
- bin  input  1  initial borrow-in; sampled on accept.
- abort  input  1  synchronous cancel of the operation in flight.
- out_valid  output  1  diff/bout hold a completed result.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
- busy  output  1  state is RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a and b into shift registers, latch bin into the borrow flop, clear bit_cnt, and go to RUN.
- RUN, one bit per edge, LSB first:
  - d_i = a_i ^ b_i ^ brw.
  - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
  - d_i shifts into the result register at the MSB end. Operand registers shift right.
  - bit_cnt increments each RUN edge.
  - The edge that processes bit WIDTH-1 loads diff and bout from the result register and brw_next, and goes to DONE.
- DONE:
  - out_valid=1. diff and bout are held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored; there is no same-cycle accept on the retire edge.
- abort:
  - Sampled in RUN or DONE only; ignored in IDLE.
  - The next state is IDLE. out_valid is never raised for the aborted op, or drops if already in DONE.
  - diff and bout keep their previous values.
  - abort has priority over out_ready and over RUN completion on the same edge.
- diff and bout keep the last completed result in IDLE. They are only updated on RUN→DONE.
- Arithmetic is unsigned modulo 2^WIDTH. bout is the only overflow indication.
- The bit counter is $clog2(WIDTH) bits and never wraps past WIDTH-1 within an operation.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, bout=0.
  - All internal shift registers, the borrow flop and bit_cnt are cleared.
- Latency: the accept edge is E0. Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH. out_valid is high in the cycle after E_WIDTH, i.e. WIDTH cycles after accept.
- Retire: the out_ready edge E_r drops out_valid. in_ready rises in the cycle after E_r.
- Minimum issue interval: WIDTH+2 cycles per operation with out_ready tied high.
- Backpressure: DONE is held for as many cycles as out_ready stays low. There is no timeout.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from inputs. No combinational input→output path exists at all.
- rst_n asserted mid-RUN or mid-DONE discards the operation immediately. The first accept is possible on the first edge after rst_n deasserts.

## Test plan
- Basic: WIDTH=8, a=0x5A, b=0x3C, bin=0 → out_valid exactly 8 cycles after accept, diff=0x1E, bout=0.
- Underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Also a=0x80, b=0x7F, bin=1 → diff=0x00, bout=0.
- Backpressure:
  - Setup: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required while held: diff and bout are stable, in_ready=0, and the new operands are not captured.
  - Required after raising out_ready: in_ready=1 one cycle later, and the next op returns the correct result.
- Abort: assert abort when bit_cnt=3 → IDLE next cycle, no out_valid pulse, diff/bout keep their prior values. The following op a=0xFF, b=0x0F, bin=1 gives diff=0xEF, bout=0.
- Reset mid-op: drop rst_n during RUN → all outputs take their reset values asynchronously, before the next clock edge. After release, an op 0x10-0x20 gives diff=0xF0, bout=1.
- Randomized check against a reference model: 1000 random ops with random out_ready stalls. diff/bout must match (a-b-bin) mod 256 and the borrow, and throughput must be exactly WIDTH+2 cycles when never stalled.
